// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: groups the fetch-stage control, program-load and IF/ID-facing signals.
// Latency: none (wires only).
// Backpressure: carries the hazard-unit stall and downstream redirect into the fetch stage.
//
// Ports (signals):
//   stall, redirect_valid, redirect_pc          hazard / branch resolution into fetch
//   imem_we, imem_waddr, imem_wdata             instruction memory program-load port
//   pc_out, instr_out, instr_valid, flush_out   fetch results toward IF/ID
// Modports: master = environment driving fetch, slave = the fetch stage itself.

interface if_fetch_stage_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 20
);
   // control into the fetch stage
   logic               stall;
   logic               redirect_valid;
   logic [PC_W-1:0]    redirect_pc;

   // program-load write port
   logic               imem_we;
   logic [PC_W-1:0]    imem_waddr;
   logic [INSTR_W-1:0] imem_wdata;

   // fetch results toward IF/ID
   logic [PC_W-1:0]    pc_out;
   logic [INSTR_W-1:0] instr_out;
   logic               instr_valid;
   logic               flush_out;

   modport master (
      output stall,
      output redirect_valid,
      output redirect_pc,
      output imem_we,
      output imem_waddr,
      output imem_wdata,
      input  pc_out,
      input  instr_out,
      input  instr_valid,
      input  flush_out
   );

   modport slave (
      input  stall,
      input  redirect_valid,
      input  redirect_pc,
      input  imem_we,
      input  imem_waddr,
      input  imem_wdata,
      output pc_out,
      output instr_out,
      output instr_valid,
      output flush_out
   );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: program counter plus synchronous-read instruction memory feeding IF/ID.
// Latency: 1 cycle from next-PC selection to aligned {pc_out, instr_out, instr_valid}.
// Backpressure: stall holds the PC and re-reads the held address; a redirect overrides stall.
//
// Ports:
//   clk   rising-edge clock for all state
//   rst   synchronous active-high reset (memory contents are kept, writes still land)
//   fif   slave side of if_fetch_stage_if:
//           in : stall, redirect_valid, redirect_pc, imem_we, imem_waddr, imem_wdata
//           out: pc_out, instr_out, instr_valid (registered), flush_out (combinational)

module if_fetch_stage #(
   parameter int              PC_W     = 8,
   parameter int              INSTR_W  = 20,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   if_fetch_stage_if.slave  fif
);

   localparam int DEPTH = 1 << PC_W;

   logic [INSTR_W-1:0] mem [DEPTH];

   logic [PC_W-1:0]    pc_q;
   logic [INSTR_W-1:0] instr_q;
   logic               valid_q;
   logic [PC_W-1:0]    next_pc;

   // Next-PC select. While instr_valid is low (first edge after reset) the
   // current PC is re-presented instead of advanced, so RESET_PC is the first
   // address handed to IF/ID. Increment wraps naturally at PC_W bits.
   always_comb begin
      next_pc = pc_q + PC_W'(1);
      if (rst) begin
         next_pc = RESET_PC;
      end else if (fif.redirect_valid) begin
         next_pc = fif.redirect_pc;
      end else if (fif.stall || !valid_q) begin
         next_pc = pc_q;
      end
   end

   // Program-load port. Not gated by reset so a program can be loaded while
   // the core is held in reset.
   always_ff @(posedge clk) begin
      if (fif.imem_we) begin
         mem[fif.imem_waddr] <= fif.imem_wdata;
      end
   end

   // Fetch register. The memory is read at next_pc on the same edge the PC
   // is updated, which keeps pc_out and instr_out aligned. Because the write
   // above is a separate non-blocking update, a same-address read on the
   // write edge returns the old word (read-first).
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= next_pc;
         instr_q <= mem[next_pc];
         valid_q <= 1'b1;
      end
   end

   assign fif.pc_out      = pc_q;
   assign fif.instr_out   = instr_q;
   assign fif.instr_valid = valid_q;

   // Kills the wrong-path instruction IF/ID captures on this same edge.
   assign fif.flush_out   = fif.redirect_valid & ~rst;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

   localparam int         PC_W     = 8;
   localparam int         INSTR_W  = 20;
   localparam logic [7:0] RESET_PC = 8'h00;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   if_fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) fif ();

   if_fetch_stage #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fif(fif)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: architectural memory image plus the expected fetch triple.
   logic [19:0] m_mem [256];
   logic [7:0]  m_pc;
   logic [19:0] m_instr;
   logic        m_valid;

   task automatic drive(input logic r, input logic s, input logic rv, input logic [7:0] rp,
                        input logic we, input logic [7:0] wa, input logic [19:0] wd);
      rst                = r;
      fif.stall          = s;
      fif.redirect_valid = rv;
      fif.redirect_pc    = rp;
      fif.imem_we        = we;
      fif.imem_waddr     = wa;
      fif.imem_wdata     = wd;
      #1;
   endtask

   // One clock edge; the model applies the fetch rules to the inputs present
   // at that edge. The memory read uses the image before this edge's write.
   task automatic tick();
      int tgt;
      @(posedge clk);
      if (rst) begin
         m_pc    = RESET_PC;
         m_instr = 20'h0;
         m_valid = 1'b0;
      end else begin
         if (fif.redirect_valid)            tgt = int'(fif.redirect_pc);
         else if (fif.stall || !m_valid)    tgt = int'(m_pc);
         else                               tgt = (int'(m_pc) + 1) % 256;
         m_pc    = 8'(tgt);
         m_instr = m_mem[tgt];
         m_valid = 1'b1;
      end
      if (fif.imem_we) m_mem[fif.imem_waddr] = fif.imem_wdata;
      #1;
   endtask

   task automatic test_reset();
      logic [19:0] v;
      for (int a = 0; a < 256; a++) begin
         if (a < 4)       v = 20'((a + 1) * 20'h11);
         else if (a == 5) v = 20'h00055;
         else             v = 20'($urandom & 32'hFFFFF);
         drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'(a), v);
         if (a == 0 || a == 255) begin
            checks++;
            if (fif.flush_out !== 1'b0) begin
               errors++;
               $display("FAIL reset_flush a=%0d got=%b exp=0", a, fif.flush_out);
            end
         end
         tick();
         if (a == 0 || a == 255) begin
            checks++;
            if ({fif.pc_out, fif.instr_out, fif.instr_valid} !== {8'h00, 20'h0, 1'b0}) begin
               errors++;
               $display("FAIL reset_state got pc=%h instr=%h v=%b exp pc=00 instr=00000 v=0",
                        fif.pc_out, fif.instr_out, fif.instr_valid);
            end
         end
      end
   endtask

   task automatic test_seq_fetch();
      logic [19:0] exp_i;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
         tick();
         exp_i = 20'((k + 1) * 20'h11);
         checks++;
         if ({fif.pc_out, fif.instr_out, fif.instr_valid} !== {8'(k), exp_i, 1'b1}) begin
            errors++;
            $display("FAIL seq_fetch got pc=%h instr=%h v=%b exp pc=%h instr=%h v=1",
                     fif.pc_out, fif.instr_out, fif.instr_valid, 8'(k), exp_i);
         end
      end
   endtask

   task automatic test_stall();
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
         tick();
         checks++;
         if ({fif.pc_out, fif.instr_out, fif.instr_valid} !== {8'h02, 20'h00033, 1'b1}) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d got pc=%h instr=%h exp pc=02 instr=00033",
                     k, fif.pc_out, fif.instr_out);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
      tick();
      checks++;
      if ({fif.pc_out, fif.instr_out} !== {8'h03, 20'h00044}) begin
         errors++;
         $display("FAIL stall_release got pc=%h instr=%h exp pc=03 instr=00044",
                  fif.pc_out, fif.instr_out);
      end
   endtask

   task automatic test_redirect_stall();
      drive(1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 20'h0);
      checks++;
      if (fif.flush_out !== 1'b1) begin
         errors++;
         $display("FAIL redir_flush got=%b exp=1", fif.flush_out);
      end
      tick();
      checks++;
      if ({fif.pc_out, fif.instr_out} !== {8'h40, m_mem[8'h40]}) begin
         errors++;
         $display("FAIL redir_target got pc=%h instr=%h exp pc=40 instr=%h",
                  fif.pc_out, fif.instr_out, m_mem[8'h40]);
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
      checks++;
      if (fif.flush_out !== 1'b0) begin
         errors++;
         $display("FAIL redir_flush_clear got=%b exp=0", fif.flush_out);
      end
      tick();
      checks++;
      if ({fif.pc_out, fif.instr_out} !== {8'h41, m_mem[8'h41]}) begin
         errors++;
         $display("FAIL redir_next got pc=%h instr=%h exp pc=41 instr=%h",
                  fif.pc_out, fif.instr_out, m_mem[8'h41]);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_pc;
      drive(1'b0, 1'b0, 1'b1, 8'hFE, 1'b0, 8'h00, 20'h0);
      tick();
      for (int k = 0; k < 4; k++) begin
         exp_pc = 8'((254 + k) % 256);
         checks++;
         if ({fif.pc_out, fif.instr_out} !== {exp_pc, m_mem[exp_pc]}) begin
            errors++;
            $display("FAIL wrap got pc=%h instr=%h exp pc=%h instr=%h",
                     fif.pc_out, fif.instr_out, exp_pc, m_mem[exp_pc]);
         end
         drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
         tick();
      end
   endtask

   task automatic test_rdw();
      // Fetch of address 5 and write of address 5 on the same edge.
      drive(1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 8'h05, 20'hABCDE);
      tick();
      checks++;
      if ({fif.pc_out, fif.instr_out} !== {8'h05, 20'h00055}) begin
         errors++;
         $display("FAIL rdw_old got pc=%h instr=%h exp pc=05 instr=00055",
                  fif.pc_out, fif.instr_out);
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
      tick();
      tick();
      drive(1'b0, 1'b0, 1'b1, 8'h05, 1'b0, 8'h00, 20'h0);
      tick();
      checks++;
      if ({fif.pc_out, fif.instr_out} !== {8'h05, 20'hABCDE}) begin
         errors++;
         $display("FAIL rdw_new got pc=%h instr=%h exp pc=05 instr=abcde",
                  fif.pc_out, fif.instr_out);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b0, 1'b1, 8'h37, 1'b0, 8'h00, 20'h0);
      tick();
      checks++;
      if (fif.pc_out !== 8'h37) begin
         errors++;
         $display("FAIL rstmid_setup got pc=%h exp pc=37", fif.pc_out);
      end
      drive(1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 8'h00, 20'h0);
      checks++;
      if (fif.flush_out !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_flush got=%b exp=0", fif.flush_out);
      end
      tick();
      checks++;
      if ({fif.pc_out, fif.instr_out, fif.instr_valid} !== {8'h00, 20'h0, 1'b0}) begin
         errors++;
         $display("FAIL rstmid_state got pc=%h instr=%h v=%b exp pc=00 instr=00000 v=0",
                  fif.pc_out, fif.instr_out, fif.instr_valid);
      end
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 20'h0);
      for (int k = 0; k < 2; k++) begin
         tick();
         checks++;
         if ({fif.pc_out, fif.instr_out, fif.instr_valid} !== {8'(k), 20'((k + 1) * 20'h11), 1'b1}) begin
            errors++;
            $display("FAIL rstmid_resume got pc=%h instr=%h v=%b exp pc=%h instr=%h v=1",
                     fif.pc_out, fif.instr_out, fif.instr_valid, 8'(k), 20'((k + 1) * 20'h11));
         end
      end
   endtask

   task automatic test_random();
      logic r, s, rv, we;
      logic [7:0] rp, wa;
      logic [19:0] wd;
      for (int n = 0; n < 600; n++) begin
         r  = ($urandom_range(0, 99) < 3);
         s  = ($urandom_range(0, 99) < 30);
         rv = ($urandom_range(0, 99) < 15);
         we = ($urandom_range(0, 99) < 20);
         rp = 8'($urandom_range(0, 255));
         wa = 8'($urandom_range(0, 255));
         wd = 20'($urandom & 32'hFFFFF);
         drive(r, s, rv, rp, we, wa, wd);
         checks++;
         if (fif.flush_out !== (rv & ~r)) begin
            errors++;
            $display("FAIL rand_flush n=%0d got=%b exp=%b", n, fif.flush_out, rv & ~r);
         end
         tick();
         checks++;
         if ({fif.pc_out, fif.instr_out, fif.instr_valid} !== {m_pc, m_instr, m_valid}) begin
            errors++;
            $display("FAIL rand_fetch n=%0d got pc=%h instr=%h v=%b exp pc=%h instr=%h v=%b",
                     n, fif.pc_out, fif.instr_out, fif.instr_valid, m_pc, m_instr, m_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_seq_fetch();
      test_stall();
      test_redirect_stall();
      test_wrap();
      test_rdw();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the program counter and a synchronous-read instruction memory.
- Presents an aligned {pc_out, instr_out, instr_valid} triple to IF/ID each cycle.
- Honours stalls from the hazard unit, takes branch/jump redirects, and generates the IF/ID flush strobe.

Parameters:
- PC_W, 8, program counter width; memory depth is 2**PC_W words.
- INSTR_W, 20, instruction word width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold the current fetch; driven by the hazard unit, the same condition that deasserts IF/ID write_en.
- redirect_valid  input  1  taken branch/jump resolved downstream.
- redirect_pc  input  PC_W  redirect target address.
- imem_we  input  1  instruction memory write enable (program load).
- imem_waddr  input  PC_W  write address.
- imem_wdata  input  INSTR_W  write data.
- pc_out  output  PC_W  PC of the instruction on instr_out; registered.
- instr_out  output  INSTR_W  fetched instruction; registered (memory read register).
- instr_valid  output  1  instr_out/pc_out hold a real fetched instruction.
- flush_out  output  1  combinational; kills the wrong-path instruction entering IF/ID.

Behaviour:
- Single clock domain: clk.
- Reset is synchronous and active-high (rst). It is sampled only on the rising edge of clk.
- Reset values:
  - pc_out = RESET_PC
  - instr_out = 0 (NOP)
  - instr_valid = 0
  - flush_out = 0 while rst = 1
- Reset does not clear memory contents. imem writes proceed during reset.
- Next-PC mux, priority high to low:
  - rst: RESET_PC
  - redirect_valid: redirect_pc
  - stall: pc_out
  - !instr_valid (first cycle after reset): pc_out
  - otherwise: pc_out + 1
- Memory read port is addressed by next_pc. On each edge: pc_out <= next_pc and instr_out <= mem[next_pc]. The two outputs are therefore always aligned, with 1-cycle fetch latency.
- instr_valid: becomes 0 on reset and 1 on every non-reset edge.
  - The first edge after reset release presents pc_out = RESET_PC, instr_out = mem[RESET_PC], instr_valid = 1.
- PC arithmetic is modulo 2**PC_W. 0xFF + 1 wraps to 0x00 silently; no flag is raised.
- Stall: pc_out and instr_out hold. The held address is re-read, so there is no separate hold register. Stall may persist for any number of cycles.
- Redirect:
  - flush_out = redirect_valid & ~rst (combinational), so IF/ID discards the wrong-path instruction captured at the same edge.
  - Next cycle: pc_out = redirect_pc, instr_out = mem[redirect_pc].
  - Redirect overrides a simultaneous stall.
  - Back-to-back redirects are each honoured; the last one wins.
- Memory writes:
  - Write-port write occurs on the edge when imem_we = 1.
  - Read and write at the same address on the same edge: the read returns the old data (read-first).
  - The written data is visible on the next fetch of that address.
- Reset mid-stream: any in-flight stall or redirect is discarded. Fetch restarts at RESET_PC as after power-up.

Test Plan:
- Program load + sequential fetch: load mem[0..3] = 0x00011, 0x00022, 0x00033, 0x00044 with rst = 1, then release rst. Required per cycle (pc_out, instr_out): (0, 0x00011), (1, 0x00022), (2, 0x00033), (3, 0x00044). instr_valid = 1 from the first post-reset edge; it is 0 during reset with instr_out = 0.
- Stall hold: stall = 1 for 3 cycles while pc_out = 2. pc_out stays 2 and instr_out stays 0x00033 for all 3 cycles. The cycle after stall drops gives pc_out = 3.
- Redirect with stall: redirect_valid = 1, redirect_pc = 0x40, stall = 1 in the same cycle. flush_out = 1 that cycle. Next cycle pc_out = 0x40 and instr_out = mem[0x40]. The following cycle pc_out = 0x41.
- Wrap-around: redirect to 0xFE. Required pc_out sequence 0xFE, 0xFF, 0x00, 0x01 with matching memory words.
- Read-during-write: while fetching address 5 (next_pc = 5), write imem_waddr = 5, imem_wdata = 0xABCDE. instr_out shows the old mem[5]. Redirect to 5 later and instr_out = 0xABCDE.
- Reset mid-operation: assert rst for 1 cycle at pc_out = 0x37 with redirect_valid = 1. Required: pc_out = 0, instr_out = 0, instr_valid = 0, flush_out = 0 during reset. Fetch resumes at address 0 and the redirect is ignored.
